// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader: collects a raster-ordered pixel stream into a ROWS x COLS
// frame register array and holds each completed frame until the consumer acks it.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_data/in_valid   pixel stream input, accepted when in_valid && in_ready
//   in_sof             marks the beat as pixel 0 of a frame
//   in_ready           registered; high while filling
//   pixels_out         flat frame array, element k = raster pixel k
//   frame_valid        registered; high while a complete frame is held
//   frame_ack          consumer has taken the held frame
//   resync_count       saturating count of SOF markers seen mid-frame
module pixel_frame_loader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROWS  = 32,
  parameter int unsigned COLS  = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_valid,
  input  logic                                in_sof,
  output logic                                in_ready,
  output logic [ROWS*COLS-1:0][WIDTH-1:0]     pixels_out,
  output logic                                frame_valid,
  input  logic                                frame_ack,
  output logic [7:0]                          resync_count
);

  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned PTR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NPIX - 1);
  localparam logic [7:0] RESYNC_MAX = 8'hFF;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;

  // Beat is taken only on the registered ready, so the first beat after reset
  // can be accepted no earlier than one edge after release.
  logic accept_c;
  assign accept_c = in_valid && in_ready && (state == FILL);

  // Index the incoming beat lands at; no write for an unsynchronised beat.
  logic             write_c;
  logic [PTR_W-1:0] write_idx_c;
  always_comb begin
    write_c     = 1'b0;
    write_idx_c = '0;
    if (accept_c) begin
      if (in_sof) begin
        write_c     = 1'b1;
        write_idx_c = '0;
      end else if (wr_ptr != '0) begin
        write_c     = 1'b1;
        write_idx_c = wr_ptr;
      end
    end
  end

  // Control state, handshake outputs and resync counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      wr_ptr       <= '0;
      in_ready     <= 1'b0;
      frame_valid  <= 1'b0;
      resync_count <= '0;
    end else begin
      case (state)
        FILL: begin
          in_ready    <= 1'b1;
          frame_valid <= 1'b0;
          if (accept_c && in_sof && (wr_ptr != '0) && (resync_count != RESYNC_MAX))
            resync_count <= resync_count + 8'd1;
          if (write_c) begin
            if (write_idx_c == LAST_IDX) begin
              state       <= HOLD;
              wr_ptr      <= '0;
              in_ready    <= 1'b0;
              frame_valid <= 1'b1;
            end else begin
              wr_ptr <= write_idx_c + PTR_W'(1);
            end
          end
        end
        HOLD: begin
          if (frame_ack) begin
            state       <= FILL;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          wr_ptr      <= '0;
          in_ready    <= 1'b0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: cleared only by reset, otherwise overwritten pixel by pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixels_out <= '0;
    end else if (write_c) begin
      pixels_out[write_idx_c] <= in_data;
    end
  end

endmodule
